if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the 5-stage LoongArch pipeline. It sits directly upstream of the decode stage: it issues fetch requests on the SRAM-like instruction bus, buffers the returned word and hands `{inst, pc}` to decode over a valid/allowin handshake. It consumes decode's one-cycle branch redirect and cancels or discards any wrong-path fetch. At most one fetch request is outstanding at any time.

## Interface
Parameters:
- `RESET_PC`, 32'h1c000000, address of the first fetch after reset.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ds_allowin` in 1: decode can accept an instruction this cycle.
- `br_collect` in 33: `{br_taken, br_target}`; `br_taken` is a one-cycle redirect pulse from decode.
- `fs_to_ds_valid` out 1: `fs_to_ds_bus` holds a valid instruction.
- `fs_to_ds_bus` out 64: `{inst[31:0], pc[31:0]}`.
- `inst_sram_req` out 1: fetch request.
- `inst_sram_wr` out 1: constant 0.
- `inst_sram_size` out 2: constant 2'b10 (word).
- `inst_sram_wstrb` out 4: constant 0.
- `inst_sram_addr` out 32: fetch address.
- `inst_sram_wdata` out 32: constant 0.
- `inst_sram_addr_ok` in 1: request accepted this cycle when `req & addr_ok`.
- `inst_sram_data_ok` in 1: `inst_sram_rdata` valid this cycle.
- `inst_sram_rdata` in 32: returned instruction word.

## Operation
- Registers: `state`, `req_pc`, `fs_pc`, `inst_buf`, `discard`.
- States:
  - S_REQ: `inst_sram_req=1`, `inst_sram_addr=req_pc`. On `addr_ok`: `fs_pc<=req_pc` -> S_WAIT.
  - S_WAIT: `req=0`. On `data_ok`: if `discard`, clear it and go to S_REQ. Otherwise `inst_buf<=rdata` -> S_HOLD.
  - S_HOLD: `req=0`. On `ds_allowin`: `req_pc<=fs_pc+4` -> S_REQ.
- Outputs:
  - `fs_to_ds_valid = (state==S_HOLD) & ~br_taken`.
  - `fs_to_ds_bus = {inst_buf, fs_pc}`.
- Branch redirect (`br_taken=1`) has priority over every other event in the same cycle:
  - S_REQ, no `addr_ok`: `req_pc<=br_target`; stay in S_REQ. The address may change while the request is unaccepted, because the slave samples the address only on `req & addr_ok`.
  - S_REQ with `addr_ok`: the wrong-path request is accepted. `req_pc<=br_target`, `discard<=1` -> S_WAIT.
  - S_WAIT, no `data_ok`: `req_pc<=br_target`, `discard<=1`.
  - S_WAIT with `data_ok`: the word is dropped. `req_pc<=br_target`, `discard<=0` -> S_REQ.
  - S_HOLD, with or without `ds_allowin`: the buffer is dropped. `req_pc<=br_target` -> S_REQ. No handoff occurs, because `valid` is masked and decode also ignores input on redirect.
- `data_ok` in S_REQ or S_HOLD is a protocol error and is ignored.
- `data_ok` never arrives in the same cycle as its `addr_ok`.
- Arithmetic: `fs_pc+4` is modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- `br_target` is used unmodified; no alignment check, since fetch exceptions are out of scope.
- Reset (including mid-request):
  - `state=S_REQ`, `req_pc=RESET_PC`, `fs_pc=0`, `inst_buf=0`, `discard=0`.
  - The instruction slave shares `reset`, so no `data_ok` for a pre-reset request is expected.

## Timing
- Output values during reset: `inst_sram_req=0` (gated by `reset`), `fs_to_ds_valid=0`, `fs_to_ds_bus=0`. Constant outputs hold their fixed values.
- The first request is asserted in the first cycle after `reset` deasserts.
- Best-case throughput is 1 instruction per 3 cycles:
  - cycle c: S_REQ with `addr_ok`.
  - cycle c+1: S_WAIT with `data_ok`.
  - cycle c+2: S_HOLD, valid, handoff if `ds_allowin`.
  - cycle c+3: S_REQ for pc+4.
- Latency: `fs_to_ds_valid` rises exactly 1 cycle after the non-discarded `data_ok`.
- Backpressure: in S_HOLD with `ds_allowin=0`, `valid` and `bus` stay stable and no request is issued.
- Redirect latency: the target request is asserted no later than 1 cycle after `br_taken`, or 1 cycle after the discarded `data_ok` if a fetch is outstanding.

## Test plan
- Reset release; slave `addr_ok=1`, `data_ok` one cycle later with `rdata=0x02800421`; `ds_allowin=1`.
  - -> Request addr 0x1c000000 in cycle 1 after reset.
  - -> `valid` in cycle 3 with bus `{0x02800421, 0x1c000000}`.
  - -> Next request 0x1c000004 in cycle 4.
- In S_HOLD, hold `ds_allowin=0` for 5 cycles.
  - -> `valid=1` and bus unchanged for all 5 cycles, `req=0`.
  - -> Request for pc+4 one cycle after `ds_allowin` rises.
- In S_WAIT, pulse `br_collect={1, 0x1c000100}`, then `data_ok` 2 cycles later.
  - -> Returned word is dropped and `valid` stays 0.
  - -> Next request address is 0x1c000100.
- Pulse `br_taken` (target 0x1c000200) in the same cycle as `data_ok`.
  - -> No handoff.
  - -> Request 0x1c000200 the next cycle, with `discard` clear.
- Hold `addr_ok=0` for 3 cycles and pulse a branch to 0x1c000300 during cycle 2.
  - -> `addr` switches to 0x1c000300.
  - -> Exactly one accepted request; its data is delivered with pc 0x1c000300.
- `RESET_PC=0xFFFFFFFC`, normal slave.
  - -> Second fetch address is 0x00000000.
  - -> Asserting `reset` while in S_WAIT returns `req` to 0 and restarts the fetch at 0xFFFFFFFC.

Source files
------------

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of a 5-stage LoongArch pipeline. Issues word fetches
// on an SRAM-like instruction bus (one request outstanding at most), buffers
// the returned word and hands {inst, pc} to decode over valid/allowin. A
// one-cycle branch redirect from decode retargets the next fetch and causes
// any in-flight wrong-path word to be discarded.
//
// Ports
//   clk                 : clock, all state updates on the rising edge
//   reset               : synchronous, active-high
//   ds_allowin          : decode can accept an instruction this cycle
//   br_collect[32:0]    : {br_taken, br_target}
//   fs_to_ds_valid      : fs_to_ds_bus holds a valid instruction
//   fs_to_ds_bus[63:0]  : {inst, pc}
//   inst_sram_req       : fetch request
//   inst_sram_wr        : tied 0 (reads only)
//   inst_sram_size[1:0] : tied 2'b10 (word)
//   inst_sram_wstrb[3:0]: tied 0
//   inst_sram_addr[31:0]: fetch address
//   inst_sram_wdata[31:0]: tied 0
//   inst_sram_addr_ok   : request accepted when req & addr_ok
//   inst_sram_data_ok   : inst_sram_rdata valid this cycle
//   inst_sram_rdata     : returned instruction word
// ----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [32:0] br_collect,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam logic [1:0] S_REQ  = 2'd0;  // request asserted, waiting for addr_ok
  localparam logic [1:0] S_WAIT = 2'd1;  // request accepted, waiting for data_ok
  localparam logic [1:0] S_HOLD = 2'd2;  // word buffered, waiting for decode

  logic        br_taken;
  logic [31:0] br_target;

  logic [1:0]  state_q,    state_d;
  logic [31:0] req_pc_q,   req_pc_d;
  logic [31:0] fs_pc_q,    fs_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        discard_q,  discard_d;

  assign br_taken  = br_collect[32];
  assign br_target = br_collect[31:0];

  // Redirect takes priority over every other event in the same cycle. A
  // redirect that races with an accepted or outstanding request marks that
  // request's data for discard instead of cancelling it on the bus.
  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the case statement leaves it unassigned (which would infer a latch).
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    fs_pc_d    = fs_pc_q;
    inst_buf_d = inst_buf_q;
    discard_d  = discard_q;

    case (state_q)
      S_REQ: begin
        if (br_taken) begin
          // Unaccepted request may be retargeted: the slave only samples the
          // address on req & addr_ok.
          req_pc_d = br_target;
          if (inst_sram_addr_ok) begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end
        end else if (inst_sram_addr_ok) begin
          fs_pc_d = req_pc_q;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (br_taken) begin
          req_pc_d = br_target;
          if (inst_sram_data_ok) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            discard_d = 1'b1;
          end
        end else if (inst_sram_data_ok) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            inst_buf_d = inst_sram_rdata;
            state_d    = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (br_taken) begin
          req_pc_d = br_target;
          state_d  = S_REQ;
        end else if (ds_allowin) begin
          req_pc_d = fs_pc_q + 32'd4;  // wraps modulo 2^32
          state_d  = S_REQ;
        end
      end

      default: state_d = S_REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      req_pc_q   <= RESET_PC;
      fs_pc_q    <= 32'd0;
      inst_buf_q <= 32'd0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      fs_pc_q    <= fs_pc_d;
      inst_buf_q <= inst_buf_d;
      discard_q  <= discard_d;
    end
  end

  // Reset is synchronous, so the registers still hold pre-reset values during
  // the first reset cycle; the outputs are gated to stay quiet throughout.
  assign inst_sram_req   = (state_q == S_REQ) & ~reset;
  assign inst_sram_addr  = req_pc_q;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'd0;

  assign fs_to_ds_valid = (state_q == S_HOLD) & ~br_taken & ~reset;
  assign fs_to_ds_bus   = reset ? 64'd0 : {inst_buf_q, fs_pc_q};

endmodule
